// File: rtl/ftdi_write_ctrl.sv
// FT245 sync-FIFO transmit controller: 16-byte buffer drained to the FTDI while TXE# is low, SIWU# on flush.
// Push at edge k drives WR#/data after edge k (commit at k+1); ready_o drops when full, TXE# high stalls WR#.
module ftdi_write_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic                  txe_n_i,
  output logic                  wr_n_o,
  output logic [7:0]            data_o,
  output logic                  siwu_n_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  push;
  logic                  commit;
  logic                  flush_pending;
  logic                  siwu_fire;

  assign ready_o = ~rst_i & (count != FULL);
  assign push    = valid_i & ready_o;
  // A byte only leaves the FIFO on an edge where the FTDI saw WR# low with room available.
  assign commit  = ~wr_n_o & ~txe_n_i;
  assign level_o = count;

  always_comb begin
    count_next = count;
    if (push && !commit)
      count_next = count + 1'b1;
    else if (!push && commit)
      count_next = count - 1'b1;
  end

  assign rd_ptr_next = commit ? rd_ptr + 1'b1 : rd_ptr;
  assign siwu_fire   = flush_pending & (count == '0) & wr_n_o;

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      wr_n_o        <= 1'b1;
      data_o        <= 8'h00;
      siwu_n_o      <= 1'b1;
      flush_pending <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      wr_n_o   <= ~((count_next != '0) & ~txe_n_i);
      // The new head is being written this edge when it lands on the next read slot.
      data_o   <= (push && (wr_ptr == rd_ptr_next)) ? data_i : mem[rd_ptr_next];
      siwu_n_o <= ~siwu_fire;
      flush_pending <= flush_i | (flush_pending & ~siwu_fire);
    end
  end

endmodule
